xaui_tx_idle_gen: RTL and testbench



---
 rtl/xaui_pkg.sv | 64 ++++++
 rtl/xaui_tx_lfsr.sv | 29 ++
 rtl/xaui_tx_idle_gen.sv | 156 +++++++++++++++
 tb/tb_xaui_tx_idle_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xaui_pkg.sv
// Shared XGMII / XAUI code points, PRBS7 taps and small mapping helpers for the
// XAUI transmit path.
package xaui_pkg;

  // XGMII control characters
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;

  // 8b/10b K-characters used in idle columns
  localparam logic [7:0] K_K = 8'hBC;
  localparam logic [7:0] K_R = 8'h1C;
  localparam logic [7:0] K_A = 8'h7C;

  // x^7 + x^6 + 1: feedback is the XOR of state bits 6 and 5
  localparam logic [6:0] PRBS7 = 7'h60;

  typedef enum logic [1:0] {
    IdleK,
    IdleR,
    IdleA
  } idle_col_e;

  typedef struct packed {
    logic [7:0] code;
    logic       bad;
  } ctrl_map_t;

  function automatic logic [6:0] prbs7_step(input logic [6:0] state);
    return {state[5:0], ^(state & PRBS7)};
  endfunction

  function automatic logic is_idle_col(input logic [31:0] txd, input logic [3:0] txc);
    return (txc == 4'hF) && (txd == {4{XGMII_IDLE}});
  endfunction

  function automatic logic [7:0] idle_code(input idle_col_e kind);
    logic [7:0] code;
    case (kind)
      IdleA:   code = K_A;
      IdleR:   code = K_R;
      default: code = K_K;
    endcase
    return code;
  endfunction

  // Control byte inside a non-idle column; unknown codes become /E/
  function automatic ctrl_map_t map_ctrl(input logic [7:0] xgmii);
    ctrl_map_t m;
    m.bad = 1'b0;
    case (xgmii)
      XGMII_START, XGMII_TERM, XGMII_ERR, XGMII_SEQ: m.code = xgmii;
      XGMII_IDLE: m.code = K_K;
      default: begin
        m.code = XGMII_ERR;
        m.bad  = 1'b1;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/xaui_tx_lfsr.sv
// PRBS7 generator advancing two steps per clock, one per XGMII column; exposes
// the state seen by column0 and the state seen by column1.
module xaui_tx_lfsr
  import xaui_pkg::*;
#(
  parameter logic [6:0] Seed = 7'h7F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [6:0] state_o,
  output logic [6:0] state_step_o
);

  logic [6:0] state_q;
  logic [6:0] state_d;

  assign state_o      = state_q;
  assign state_step_o = prbs7_step(state_q);
  assign state_d      = prbs7_step(state_step_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/xaui_tx_idle_gen.sv
// XGMII-to-XAUI transmit mapper: K-character translation of control bytes and
// ||A||/||K||/||R|| idle sequence generation, two columns per clock.
module xaui_tx_idle_gen
  import xaui_pkg::*;
#(
  parameter logic [6:0]  LFSR_SEED = 7'h7F,
  parameter int unsigned A_MIN     = 16
) (
  input  logic        xaui_clk,
  input  logic        mgt_tx_rst,
  input  logic        tx_enable,
  input  logic [63:0] xgmii_txd,
  input  logic [7:0]  xgmii_txc,
  output logic [63:0] mgt_txdata,
  output logic [7:0]  mgt_txcharisk,
  output logic        tx_ctrl_err
);

  // Wide enough for A_MIN + 15
  localparam int unsigned ACntW = $clog2(A_MIN + 16);
  localparam logic [ACntW-1:0] ACntInit = ACntW'(A_MIN) + ACntW'(LFSR_SEED[3:0]);

  typedef struct packed {
    logic [31:0]      data;
    logic [3:0]       k;
    logic             err;
    logic [ACntW-1:0] a_cnt;
  } col_res_t;

  // Stage 1: input capture and idle classification
  logic [63:0] txd_q;
  logic [7:0]  txc_q;
  logic [1:0]  idle_d, idle_q;

  always_comb begin
    idle_d[0] = !tx_enable || is_idle_col(xgmii_txd[31:0], xgmii_txc[3:0]);
    idle_d[1] = !tx_enable || is_idle_col(xgmii_txd[63:32], xgmii_txc[7:4]);
  end

  always_ff @(posedge xaui_clk) begin
    if (mgt_tx_rst) begin
      txd_q  <= {8{XGMII_IDLE}};
      txc_q  <= 8'hFF;
      idle_q <= 2'b11;
    end else begin
      txd_q  <= xgmii_txd;
      txc_q  <= xgmii_txc;
      idle_q <= idle_d;
    end
  end

  // Stage 2: substitution with column-serial idle state
  logic [6:0]       lfsr_cur, lfsr_nxt;
  logic [ACntW-1:0] a_cnt_q, a_cnt_d;
  logic             prev_idle_q, prev_idle_d;
  logic [63:0]      txdata_q, txdata_d;
  logic [7:0]       charisk_q, charisk_d;
  logic             ctrl_err_q, ctrl_err_d;
  col_res_t         col0_res, col1_res;

  xaui_tx_lfsr #(
    .Seed(LFSR_SEED)
  ) u_lfsr (
    .clk_i       (xaui_clk),
    .rst_i       (mgt_tx_rst),
    .state_o     (lfsr_cur),
    .state_step_o(lfsr_nxt)
  );

  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^{lfsr_cur[6:4], lfsr_nxt[6:4]};

  function automatic col_res_t process_col(
    input logic             idle,
    input logic [31:0]      txd,
    input logic [3:0]       txc,
    input logic [ACntW-1:0] a_cnt,
    input logic             prev_idle,
    input logic [3:0]       lfsr_lo
  );
    col_res_t  r;
    ctrl_map_t m;
    idle_col_e kind;
    r.data  = '0;
    r.k     = '0;
    r.err   = 1'b0;
    r.a_cnt = a_cnt;
    if (idle) begin
      if (a_cnt == '0) begin
        kind    = IdleA;
        r.a_cnt = ACntW'(A_MIN) + ACntW'(lfsr_lo);
      end else begin
        // First idle after a non-idle column is always ||K||
        kind    = (prev_idle && !lfsr_lo[0]) ? IdleR : IdleK;
        r.a_cnt = a_cnt - 1'b1;
      end
      r.data = {4{idle_code(kind)}};
      r.k    = 4'hF;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (txc[l]) begin
          m                = map_ctrl(txd[l*8+:8]);
          r.data[l*8+:8]   = m.code;
          r.k[l]           = 1'b1;
          r.err            = r.err | m.bad;
        end else begin
          r.data[l*8+:8] = txd[l*8+:8];
        end
      end
      // ||A|| is deferred: the count parks at zero until an idle column
      if (a_cnt != '0) begin
        r.a_cnt = a_cnt - 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    col0_res = process_col(idle_q[0], txd_q[31:0], txc_q[3:0], a_cnt_q, prev_idle_q,
                           lfsr_cur[3:0]);
    col1_res = process_col(idle_q[1], txd_q[63:32], txc_q[7:4], col0_res.a_cnt, idle_q[0],
                           lfsr_nxt[3:0]);
    txdata_d  = '0;
    charisk_d = '0;
    for (int l = 0; l < 4; l++) begin
      txdata_d[l*16+:8]   = col0_res.data[l*8+:8];
      txdata_d[l*16+8+:8] = col1_res.data[l*8+:8];
      charisk_d[l*2]      = col0_res.k[l];
      charisk_d[l*2+1]    = col1_res.k[l];
    end
    ctrl_err_d  = col0_res.err | col1_res.err;
    a_cnt_d     = col1_res.a_cnt;
    prev_idle_d = idle_q[1];
  end

  always_ff @(posedge xaui_clk) begin
    if (mgt_tx_rst) begin
      txdata_q    <= {8{K_K}};
      charisk_q   <= 8'hFF;
      ctrl_err_q  <= 1'b0;
      a_cnt_q     <= ACntInit;
      prev_idle_q <= 1'b0;
    end else begin
      txdata_q    <= txdata_d;
      charisk_q   <= charisk_d;
      ctrl_err_q  <= ctrl_err_d;
      a_cnt_q     <= a_cnt_d;
      prev_idle_q <= prev_idle_d;
    end
  end

  assign mgt_txdata    = txdata_q;
  assign mgt_txcharisk = charisk_q;
  assign tx_ctrl_err   = ctrl_err_q;

endmodule

// File: tb/tb_xaui_tx_idle_gen.sv
// Bench for xaui_tx_idle_gen: a column-level reference model fills a scoreboard
// at drive time; scenario tasks add targeted checks on specific output columns.
module tb_xaui_tx_idle_gen;

  localparam logic [63:0] IDLE64 = {8{8'h07}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [63:0] txd = {8{8'h07}};
  logic [7:0]  txc = 8'hFF;
  logic [63:0] dout;
  logic [7:0]  kout;
  logic        err_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  k;
    logic        err;
  } exp_t;

  exp_t sb[$];

  logic [6:0]  m_lfsr;
  int unsigned m_acnt;
  logic        m_prev;

  xaui_tx_idle_gen #(
    .LFSR_SEED(7'h7F),
    .A_MIN    (16)
  ) dut (
    .xaui_clk     (clk),
    .mgt_tx_rst   (rst),
    .tx_enable    (tx_en),
    .xgmii_txd    (txd),
    .xgmii_txc    (txc),
    .mgt_txdata   (dout),
    .mgt_txcharisk(kout),
    .tx_ctrl_err  (err_out)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] obs_byte(input int col, input int lane);
    return dout[lane*16+col*8+:8];
  endfunction

  function automatic logic obs_k(input int col, input int lane);
    return kout[lane*2+col];
  endfunction

  task automatic model_reset();
    m_lfsr = 7'h7F;
    m_acnt = 31;
    m_prev = 1'b0;
  endtask

  task automatic model_col(input logic en, input logic [31:0] d, input logic [3:0] c,
                           output logic [31:0] od, output logic [3:0] ok, output logic oe);
    logic       idle;
    logic [7:0] b;
    idle = !en || (c == 4'hF && d == 32'h0707_0707);
    oe   = 1'b0;
    od   = '0;
    ok   = '0;
    if (idle) begin
      if (m_acnt == 0) begin
        b      = 8'h7C;
        m_acnt = 16 + m_lfsr[3:0];
      end else begin
        b      = (m_prev && !m_lfsr[0]) ? 8'h1C : 8'hBC;
        m_acnt = m_acnt - 1;
      end
      od = {4{b}};
      ok = 4'hF;
    end else begin
      for (int l = 0; l < 4; l++) begin
        b = d[l*8+:8];
        if (!c[l]) begin
          od[l*8+:8] = b;
        end else begin
          ok[l] = 1'b1;
          case (b)
            8'hFB, 8'hFD, 8'hFE, 8'h9C: od[l*8+:8] = b;
            8'h07:   od[l*8+:8] = 8'hBC;
            default: begin
              od[l*8+:8] = 8'hFE;
              oe         = 1'b1;
            end
          endcase
        end
      end
      if (m_acnt != 0) m_acnt = m_acnt - 1;
    end
    m_prev = idle;
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  endtask

  task automatic model_pair(input logic en, input logic [63:0] d, input logic [7:0] c,
                            output exp_t e);
    logic [31:0] od;
    logic [3:0]  ok;
    logic        oe;
    e = '0;
    for (int col = 0; col < 2; col++) begin
      model_col(en, d[col*32+:32], c[col*4+:4], od, ok, oe);
      for (int l = 0; l < 4; l++) begin
        e.data[l*16+col*8+:8] = od[l*8+:8];
        e.k[l*2+col]          = ok[l];
      end
      e.err = e.err | oe;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic tick(input logic r, input logic en, input logic [63:0] d, input logic [7:0] c);
    exp_t e;
    if (!r && rst) begin
      model_reset();
      model_pair(1'b0, IDLE64, 8'hFF, e);
      sb.push_back(e);
    end
    rst   = r;
    tx_en = en;
    txd   = d;
    txc   = c;
    if (!r) begin
      model_pair(en, d, c, e);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  // Scoreboard checker
  initial begin
    logic rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      n_checks++;
      if (rst_s) begin
        sb.delete();
        if ({dout, kout, err_out} !== {{8{8'hBC}}, 8'hFF, 1'b0}) begin
          n_errors++;
          $display("FAIL sb_reset: got data=%h k=%h err=%b want data=%h k=ff err=0",
                   dout, kout, err_out, {8{8'hBC}});
        end
      end else if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_underflow: got no expected entry, want one queued");
      end else begin
        e = sb.pop_front();
        if ({dout, kout, err_out} !== {e.data, e.k, e.err}) begin
          n_errors++;
          $display("FAIL sb_compare: got data=%h k=%h err=%b want data=%h k=%h err=%b",
                   dout, kout, err_out, e.data, e.k, e.err);
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, IDLE64, 8'hFF);
    n_checks++;
    if (dout !== {8{8'hBC}} || kout !== 8'hFF || err_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: got data=%h k=%h err=%b want data=%h k=ff err=0",
               dout, kout, err_out, {8{8'hBC}});
    end
  endtask

  // Releases reset with tx_enable low and checks the idle-only sequence
  task automatic run_idle_after_reset(input string tag);
    int a_pos[$];
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick(1'b0, 1'b0, IDLE64, 8'hFF);
      for (int col = 0; col < 2; col++) begin
        int         n;
        logic [7:0] b;
        n = cyc * 2 + col;
        b = obs_byte(col, 0);
        if (b == 8'h7C) a_pos.push_back(n);
        if (n == 0) begin
          n_checks++;
          if (b !== 8'hBC) begin
            n_errors++;
            $display("FAIL %s_first_col: got %h want bc", tag, b);
          end
        end else if (n <= 30) begin
          n_checks++;
          if (b !== 8'hBC && b !== 8'h1C) begin
            n_errors++;
            $display("FAIL %s_no_a_col%0d: got %h want bc or 1c", tag, n, b);
          end
        end else if (n == 31) begin
          n_checks++;
          if (b !== 8'h7C) begin
            n_errors++;
            $display("FAIL %s_first_a: got %h at column 31 want 7c", tag, b);
          end
        end
      end
    end
    n_checks++;
    if (a_pos.size() < 2) begin
      n_errors++;
      $display("FAIL %s_a_count: got %0d A columns want at least 2", tag, a_pos.size());
    end
    for (int i = 1; i < a_pos.size(); i++) begin
      n_checks++;
      if (a_pos[i] - a_pos[i-1] < 16 || a_pos[i] - a_pos[i-1] > 31) begin
        n_errors++;
        $display("FAIL %s_a_spacing: got %0d want 16..31", tag, a_pos[i] - a_pos[i-1]);
      end
    end
  endtask

  task automatic test_idle_sequence();
    run_idle_after_reset("idle");
  endtask

  task automatic test_frame();
    tick(1'b0, 1'b1, {32'h4433_2211, 32'h5555_55FB}, 8'h01);
    tick(1'b0, 1'b1, {32'h0C0B_0A09, 32'h0807_0605}, 8'h00);
    n_checks++;
    if (obs_byte(0, 0) !== 8'hFB || obs_k(0, 0) !== 1'b1 || obs_byte(0, 1) !== 8'h55 ||
        obs_k(0, 1) !== 1'b0 || obs_byte(1, 1) !== 8'h22 || obs_k(1, 1) !== 1'b0) begin
      n_errors++;
      $display("FAIL frame_start: got data=%h k=%h want FB/K lane0, 55 lane1, 22 col1", dout,
               kout);
    end
    tick(1'b0, 1'b1, {32'h0707_0707, 32'h07FD_BBAA}, 8'hFC);
    n_checks++;
    if (kout !== 8'h00) begin
      n_errors++;
      $display("FAIL frame_data_k: got %h want 00", kout);
    end
    tick(1'b0, 1'b1, IDLE64, 8'hFF);
    n_checks++;
    if (obs_byte(0, 0) !== 8'hAA || obs_k(0, 0) !== 1'b0 || obs_byte(0, 1) !== 8'hBB ||
        obs_k(0, 1) !== 1'b0 || obs_byte(0, 2) !== 8'hFD || obs_k(0, 2) !== 1'b1 ||
        obs_byte(0, 3) !== 8'hBC || obs_k(0, 3) !== 1'b1) begin
      n_errors++;
      $display("FAIL frame_term: got data=%h k=%h want AA,BB,FD/K,BC/K in column0", dout, kout);
    end
    n_checks++;
    if (obs_byte(1, 0) !== 8'hBC && obs_byte(1, 0) !== 8'h7C) begin
      n_errors++;
      $display("FAIL frame_post_term: got %h want bc or 7c", obs_byte(1, 0));
    end
    tick(1'b0, 1'b1, IDLE64, 8'hFF);
  endtask

  task automatic test_bad_ctrl();
    tick(1'b0, 1'b1, {32'h0707_0707, 32'h335A_2211}, 8'hF4);
    tick(1'b0, 1'b1, IDLE64, 8'hFF);
    n_checks++;
    if (obs_byte(0, 2) !== 8'hFE || obs_k(0, 2) !== 1'b1 || err_out !== 1'b1) begin
      n_errors++;
      $display("FAIL bad_ctrl: got byte=%h k=%b err=%b want fe k=1 err=1", obs_byte(0, 2),
               obs_k(0, 2), err_out);
    end
    tick(1'b0, 1'b1, IDLE64, 8'hFF);
    n_checks++;
    if (err_out !== 1'b0) begin
      n_errors++;
      $display("FAIL bad_ctrl_pulse: got err=%b want 0", err_out);
    end
  endtask

  task automatic test_a_deferred();
    tick(1'b0, 1'b1, {$urandom, 24'h123456, 8'hFB}, 8'h01);
    for (int i = 1; i <= 19; i++) begin
      tick(1'b0, 1'b1, {$urandom, $urandom}, 8'h00);
      n_checks++;
      if (kout !== ((i == 1) ? 8'h01 : 8'h00)) begin
        n_errors++;
        $display("FAIL a_deferred_in_frame%0d: got k=%h want %h", i, kout,
                 (i == 1) ? 8'h01 : 8'h00);
      end
    end
    tick(1'b0, 1'b1, {32'h0707_0707, 32'h0707_07FD}, 8'hFF);
    n_checks++;
    if (kout !== 8'h00) begin
      n_errors++;
      $display("FAIL a_deferred_last_data: got k=%h want 00", kout);
    end
    tick(1'b0, 1'b1, IDLE64, 8'hFF);
    n_checks++;
    if (obs_byte(0, 0) !== 8'hFD || obs_byte(1, 0) !== 8'h7C || obs_byte(1, 1) !== 8'h7C ||
        obs_byte(1, 2) !== 8'h7C || obs_byte(1, 3) !== 8'h7C) begin
      n_errors++;
      $display("FAIL a_deferred_after_t: got data=%h want FD then 7c on all lanes", dout);
    end
  endtask

  task automatic test_idle_after_term();
    logic [31:0] cd[$];
    logic [3:0]  cc[$];
    bit          at[$];
    int          np;
    for (int f = 0; f < 1000; f++) begin
      int          t;
      int          nd;
      int          ni;
      logic [31:0] d;
      logic [3:0]  c;
      cd.push_back({$urandom_range(0, 32'hFF_FFFF), 8'hFB}[31:0]);
      cc.push_back(4'h1);
      at.push_back(1'b0);
      nd = $urandom_range(0, 4);
      for (int i = 0; i < nd; i++) begin
        cd.push_back($urandom);
        cc.push_back(4'h0);
        at.push_back(1'b0);
      end
      t = $urandom_range(0, 3);
      d = $urandom;
      c = 4'h0;
      for (int l = 0; l < 4; l++) begin
        if (l == t) begin
          d[l*8+:8] = 8'hFD;
          c[l]      = 1'b1;
        end else if (l > t) begin
          d[l*8+:8] = 8'h07;
          c[l]      = 1'b1;
        end
      end
      cd.push_back(d);
      cc.push_back(c);
      at.push_back(1'b0);
      ni = $urandom_range(1, 3);
      for (int i = 0; i < ni; i++) begin
        cd.push_back(32'h0707_0707);
        cc.push_back(4'hF);
        at.push_back(i == 0);
      end
    end
    if (cd.size() % 2 != 0) begin
      cd.push_back(32'h0707_0707);
      cc.push_back(4'hF);
      at.push_back(1'b0);
    end
    np = cd.size() / 2;
    for (int p = 0; p <= np; p++) begin
      if (p < np) tick(1'b0, 1'b1, {cd[2*p+1], cd[2*p]}, {cc[2*p+1], cc[2*p]});
      else tick(1'b0, 1'b1, IDLE64, 8'hFF);
      if (p > 0) begin
        for (int col = 0; col < 2; col++) begin
          if (at[2*(p-1)+col]) begin
            n_checks++;
            if (obs_byte(col, 0) !== 8'hBC && obs_byte(col, 0) !== 8'h7C) begin
              n_errors++;
              $display("FAIL idle_after_term pair%0d col%0d: got %h want bc or 7c", p - 1, col,
                       obs_byte(col, 0));
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    tick(1'b0, 1'b1, {32'hDEAD_BEEF, 32'h5555_55FB}, 8'h01);
    tick(1'b0, 1'b1, {32'h0102_0304, 32'hA5A5_5A5A}, 8'h00);
    tick(1'b1, 1'b0, {32'h0506_0708, 32'hC3C3_3C3C}, 8'h00);
    n_checks++;
    if (dout !== {8{8'hBC}} || kout !== 8'hFF || err_out !== 1'b0) begin
      n_errors++;
      $display("FAIL midframe_reset: got data=%h k=%h err=%b want data=%h k=ff err=0", dout,
               kout, err_out, {8{8'hBC}});
    end
    run_idle_after_reset("post_rst");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_sequence();
    test_frame();
    test_bad_ctrl();
    test_a_deferred();
    test_idle_after_term();
    test_reset_midframe();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, IDLE64, 8'hFF);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
